vector_loader: RTL and testbench

Write-side feeder for a compute atom's register file. Accepts a narrow valid/ready stream of `BEAT_LANES`-wide beats, assembles them into full `LANES`-wide vectors, and issues one register-file write per vector at auto-incrementing addresses starting from a programmed base. Its outputs connect directly to the atom's `i_waddr`/`i_wdata`/`i_wvalid` write port. A start/busy/done control interface lets the instruction controller load a block of `NUM` vectors and wait for completion.

---
 rtl/vector_loader_if.sv | 30 +++
 rtl/vector_loader.sv | 106 ++++++++++
 tb/tb_vector_loader.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/vector_loader_if.sv
// Beat stream, register-file write port and start/busy/done control of vector_loader.
// Signal names are from the loader's point of view (i_ = into the loader).
interface vector_loader_if #(
  parameter int unsigned IDATAW     = 8,
  parameter int unsigned LANES      = 40,
  parameter int unsigned BEAT_LANES = 8,
  parameter int unsigned RF_ADDRW   = 9
);
  logic                                i_start;
  logic [RF_ADDRW-1:0]                 i_base_addr;
  logic [RF_ADDRW:0]                   i_num_vecs;
  logic                                o_busy;
  logic                                o_done;
  logic [0:BEAT_LANES-1][IDATAW-1:0]   i_data;
  logic                                i_valid;
  logic                                o_ready;
  logic [RF_ADDRW-1:0]                 o_waddr;
  logic [0:LANES-1][IDATAW-1:0]        o_wdata;
  logic                                o_wvalid;

  modport master (
    output i_start, i_base_addr, i_num_vecs, i_data, i_valid,
    input  o_busy, o_done, o_ready, o_waddr, o_wdata, o_wvalid
  );

  modport slave (
    input  i_start, i_base_addr, i_num_vecs, i_data, i_valid,
    output o_busy, o_done, o_ready, o_waddr, o_wdata, o_wvalid
  );
endinterface

// File: rtl/vector_loader.sv
// Assembles BEAT_LANES-wide beats into LANES-wide vectors and writes them to the
// register file at auto-incrementing (wrapping) addresses.
module vector_loader #(
  parameter int unsigned IDATAW     = 8,
  parameter int unsigned LANES      = 40,
  parameter int unsigned BEAT_LANES = 8,
  parameter int unsigned RF_DEPTH   = 512,
  parameter int unsigned RF_ADDRW   = $clog2(RF_DEPTH)
) (
  input logic           clk,
  input logic           rst,
  vector_loader_if.slave io_bus
);
  localparam int unsigned BEATS  = LANES / BEAT_LANES;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {StIdle, StFill, StFlush} state_e;

  state_e                       r_state;
  logic [BEAT_W-1:0]            r_beat;
  logic [RF_ADDRW:0]            r_vec_cnt;
  logic [RF_ADDRW:0]            r_num;
  logic [RF_ADDRW-1:0]          r_addr;
  logic [RF_ADDRW-1:0]          r_waddr;
  logic [0:LANES-1][IDATAW-1:0] r_asm;
  logic [0:LANES-1][IDATAW-1:0] r_wdata;
  logic                         r_wvalid;

  logic [0:LANES-1][IDATAW-1:0] w_vec;
  logic                         w_xfer;
  logic                         w_last_beat;
  logic                         w_last_vec;
  logic [RF_ADDRW-1:0]          w_addr_nxt;

  assign w_xfer      = (r_state == StFill) && io_bus.i_valid;
  assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));
  assign w_last_vec  = ((r_vec_cnt + 1'b1) == r_num);
  // Depth need not be a power of two, so wrap on an explicit compare.
  assign w_addr_nxt  = (r_addr == RF_ADDRW'(RF_DEPTH - 1)) ? '0 : r_addr + 1'b1;

  // Assembly buffer with the current beat merged in at its lane slot.
  always_comb begin
    w_vec = r_asm;
    for (int b = 0; b < BEATS; b++) begin
      if (r_beat == BEAT_W'(b)) begin
        for (int j = 0; j < BEAT_LANES; j++) begin
          w_vec[b*BEAT_LANES + j] = io_bus.i_data[j];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= StIdle;
      r_beat    <= '0;
      r_vec_cnt <= '0;
      r_num     <= '0;
      r_addr    <= '0;
      r_waddr   <= '0;
      r_asm     <= '0;
      r_wdata   <= '0;
      r_wvalid  <= 1'b0;
    end else begin
      r_wvalid <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (io_bus.i_start) begin
            r_addr    <= io_bus.i_base_addr;
            r_num     <= io_bus.i_num_vecs;
            r_beat    <= '0;
            r_vec_cnt <= '0;
            r_state   <= (io_bus.i_num_vecs != '0) ? StFill : StFlush;
          end
        end
        StFill: begin
          if (w_xfer) begin
            r_asm <= w_vec;
            if (w_last_beat) begin
              r_wdata   <= w_vec;
              r_waddr   <= r_addr;
              r_wvalid  <= 1'b1;
              r_beat    <= '0;
              r_addr    <= w_addr_nxt;
              r_vec_cnt <= r_vec_cnt + 1'b1;
              if (w_last_vec) begin
                r_state <= StFlush;
              end
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        StFlush: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.o_busy   = (r_state != StIdle);
  assign io_bus.o_done   = (r_state == StFlush);
  assign io_bus.o_ready  = (r_state == StFill);
  assign io_bus.o_waddr  = r_waddr;
  assign io_bus.o_wdata  = r_wdata;
  assign io_bus.o_wvalid = r_wvalid;
endmodule

// File: tb/tb_vector_loader.sv
// Randomised bench for vector_loader: expected writes are rebuilt from the list of
// transferred elements, the base address and the count.
module tb_vector_loader;
  localparam int unsigned IDATAW     = 8;
  localparam int unsigned LANES      = 40;
  localparam int unsigned BEAT_LANES = 8;
  localparam int unsigned RF_DEPTH   = 512;
  localparam int unsigned RF_ADDRW   = $clog2(RF_DEPTH);
  localparam int unsigned BEATS      = LANES / BEAT_LANES;
  localparam int unsigned VW         = LANES * IDATAW;

  typedef logic [0:LANES-1][IDATAW-1:0] vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  vector_loader_if #(
    .IDATAW    (IDATAW),
    .LANES     (LANES),
    .BEAT_LANES(BEAT_LANES),
    .RF_ADDRW  (RF_ADDRW)
  ) bus ();

  vector_loader #(
    .IDATAW    (IDATAW),
    .LANES     (LANES),
    .BEAT_LANES(BEAT_LANES),
    .RF_DEPTH  (RF_DEPTH),
    .RF_ADDRW  (RF_ADDRW)
  ) u_dut (
    .clk   (clk),
    .rst   (rst),
    .io_bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed writes and done pulses
  logic [RF_ADDRW-1:0] act_addr_q[$];
  vec_t                act_data_q[$];
  int unsigned         act_cyc_q[$];
  int unsigned         done_q[$];
  // Model state: every element accepted, and the cycle of every beat transfer
  logic [IDATAW-1:0]   elem_q[$];
  int unsigned         xfer_q[$];

  always @(negedge clk) begin
    if (rst) begin
      if (bus.o_wvalid) begin
        act_addr_q.push_back(bus.o_waddr);
        act_data_q.push_back(bus.o_wdata);
        act_cyc_q.push_back(cyc);
      end
      if (bus.o_done) done_q.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    act_addr_q.delete();
    act_data_q.delete();
    act_cyc_q.delete();
    done_q.delete();
    elem_q.delete();
    xfer_q.delete();
  endtask

  // Present one beat (valid with probability vpct%) and log it if it transfers.
  task automatic offer_beat(input int vpct, input bit ramp);
    bus.i_valid = ($urandom_range(99) < vpct);
    for (int j = 0; j < BEAT_LANES; j++)
      bus.i_data[j] = ramp ? IDATAW'(elem_q.size() + j) : IDATAW'($urandom);
    if (bus.i_valid && bus.o_ready) begin
      for (int j = 0; j < BEAT_LANES; j++) elem_q.push_back(bus.i_data[j]);
      xfer_q.push_back(cyc);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_busy"}, bus.o_busy, 0);
    check_eq({tag, "_done"}, bus.o_done, 0);
    check_eq({tag, "_ready"}, bus.o_ready, 0);
    check_eq({tag, "_wvalid"}, bus.o_wvalid, 0);
    check_eq({tag, "_waddr"}, bus.o_waddr, 0);
    check_eq({tag, "_wdata"}, bus.o_wdata, 0);
  endtask

  task automatic run_load(input int base, input int num, input int vpct, input bit ramp,
                          input bit busy_start, input bit flush_start);
    int unsigned c;
    int budget;
    vec_t ev;
    clear_logs();
    bus.i_start     = 1'b1;
    bus.i_base_addr = RF_ADDRW'(base);
    bus.i_num_vecs  = (RF_ADDRW + 1)'(num);
    c = cyc;
    step();
    bus.i_start = 1'b0;
    check_eq("busy_after_start", bus.o_busy, 1);
    if (num > 0) check_eq("ready_after_start", bus.o_ready, 1);
    if (flush_start) begin
      bus.i_start     = 1'b1;
      bus.i_base_addr = RF_ADDRW'(77);
      bus.i_num_vecs  = (RF_ADDRW + 1)'(3);
      step();
      bus.i_start = 1'b0;
      check_eq("busy_c2_after_flush_start", bus.o_busy, 0);
    end
    budget = 0;
    while (xfer_q.size() < num * BEATS && budget < 4000) begin
      offer_beat(vpct, ramp);
      if (busy_start && xfer_q.size() == BEATS + 2) begin
        bus.i_start     = 1'b1;
        bus.i_base_addr = RF_ADDRW'(99);
        bus.i_num_vecs  = (RF_ADDRW + 1)'(2);
      end else begin
        bus.i_start = 1'b0;
      end
      step();
      budget++;
    end
    bus.i_valid = 1'b0;
    bus.i_start = 1'b0;
    check_eq("beats_accepted", xfer_q.size(), num * BEATS);
    budget = 0;
    while (done_q.size() == 0 && budget < 50) begin
      step();
      budget++;
    end
    check_eq("busy_after_done", bus.o_busy, 0);
    repeat (3) step();
    check_eq("busy_idle_tail", bus.o_busy, 0);
    check_eq("n_done", done_q.size(), 1);
    check_eq("n_writes", act_addr_q.size(), num);
    if (done_q.size() > 0)
      check_eq("done_cycle", done_q[0],
               (num > 0 && xfer_q.size() > 0) ? xfer_q[xfer_q.size()-1] + 1 : c + 1);
    if (vpct >= 100 && num > 0 && xfer_q.size() == num * BEATS) begin
      check_eq("first_beat_cycle", xfer_q[0], c + 1);
      check_eq("beat_span", xfer_q[xfer_q.size()-1] - xfer_q[0], num * BEATS - 1);
    end
    for (int v = 0; v < num && v < act_addr_q.size(); v++) begin
      for (int k = 0; k < LANES; k++)
        ev[k] = (v * LANES + k < elem_q.size()) ? elem_q[v*LANES + k] : '0;
      check_eq($sformatf("waddr_v%0d", v), act_addr_q[v], (base + v) % RF_DEPTH);
      check_eq($sformatf("wdata_v%0d", v), act_data_q[v], ev);
      if ((v + 1) * BEATS <= xfer_q.size())
        check_eq($sformatf("wcycle_v%0d", v), act_cyc_q[v], xfer_q[(v+1)*BEATS - 1] + 1);
    end
  endtask

  initial begin
    bus.i_start     = 1'b0;
    bus.i_base_addr = '0;
    bus.i_num_vecs  = '0;
    bus.i_data      = '0;
    bus.i_valid     = 1'b0;
    rst = 1'b0;
    repeat (3) step();
    check_outputs_zero("reset");
    rst = 1'b1;
    step();

    run_load(10, 1, 100, 1'b1, 1'b0, 1'b0);   // single vector, ramp 0..39
    run_load(510, 3, 100, 1'b0, 1'b0, 1'b0);  // wrap 510, 511, 0
    run_load(int'($urandom_range(RF_DEPTH - 1)), 4, 50, 1'b0, 1'b0, 1'b0);
    run_load(300, 0, 100, 1'b0, 1'b0, 1'b1);  // zero count, start during flush
    run_load(5, 4, 100, 1'b0, 1'b1, 1'b0);    // start with base 99 while busy

    // Reset after 3 beats of vector 2
    clear_logs();
    bus.i_start     = 1'b1;
    bus.i_base_addr = RF_ADDRW'(20);
    bus.i_num_vecs  = (RF_ADDRW + 1)'(3);
    step();
    bus.i_start = 1'b0;
    for (int i = 0; i < 60 && xfer_q.size() < BEATS + 3; i++) begin
      offer_beat(100, 1'b0);
      step();
    end
    bus.i_valid = 1'b0;
    rst = 1'b0;
    step();
    check_outputs_zero("midreset");
    rst = 1'b1;
    repeat (8) step();
    check_eq("midreset_writes", act_addr_q.size(), 1);
    check_eq("midreset_busy", bus.o_busy, 0);
    run_load(0, 1, 100, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 3; t++)
      run_load(int'($urandom_range(RF_DEPTH - 1)), int'($urandom_range(3, 1)), 70,
               1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
